// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings and the combinational decode rules for the
// decode/register-file stage.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RNONE   = 4'hF;
    localparam logic [3:0] RSP_IDX = 4'h4;

    typedef struct packed {
        logic [3:0] src_a;
        logic [3:0] src_b;
        logic [3:0] dst_e;
        logic [3:0] dst_m;
    } decode_t;

    function automatic decode_t y86_decode(input logic [3:0] icode,
                                           input logic [3:0] ra,
                                           input logic [3:0] rb,
                                           input logic [3:0] rsp);
        decode_t d;
        d.src_a = RNONE;
        d.src_b = RNONE;
        d.dst_e = RNONE;
        d.dst_m = RNONE;
        case (icode)
            IRRMOVQ, IRMMOVQ, IOPQ, IPUSHQ: d.src_a = ra;
            IPOPQ, IRET:                    d.src_a = rsp;
            default: ;
        endcase
        case (icode)
            IRMMOVQ, IMRMOVQ, IOPQ:         d.src_b = rb;
            ICALL, IRET, IPUSHQ, IPOPQ:     d.src_b = rsp;
            default: ;
        endcase
        case (icode)
            IRRMOVQ, IIRMOVQ, IOPQ:         d.dst_e = rb;
            ICALL, IRET, IPUSHQ, IPOPQ:     d.dst_e = rsp;
            default: ;
        endcase
        case (icode)
            IMRMOVQ, IPOPQ:                 d.dst_m = ra;
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/y86_scoreboard.sv
// Per-register outstanding-write counters: increments on issue, releases on
// writeback, and answers "source busy" and "destination would overflow".
module y86_scoreboard #(
    parameter int NREGS = 15,
    parameter int SB_W  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc_en,
    input  logic [3:0] inc_e,
    input  logic [3:0] inc_m,
    input  logic       rel_e_en,
    input  logic       wr_e_en,
    input  logic [3:0] rel_e,
    input  logic       rel_m_en,
    input  logic [3:0] rel_m,
    input  logic [3:0] query_a,
    input  logic [3:0] query_b,
    output logic       busy_a,
    output logic       busy_b,
    output logic       sat
);
    import y86_pkg::*;

    localparam int              CW   = SB_W + 1;
    localparam logic [CW-1:0]   CMAX = CW'((1 << SB_W) - 1);

    logic [SB_W-1:0] count      [NREGS];
    logic [SB_W-1:0] count_next [NREGS];
    logic [NREGS-1:0] sat_vec;
    logic [NREGS-1:0] busy_vec;

    always_comb begin
        logic [1:0]    rel_amt;
        logic [1:0]    inc_amt;
        logic [CW-1:0] after_rel;
        logic [CW-1:0] sum;
        logic          wr_hit;
        sat_vec  = '0;
        busy_vec = '0;
        for (int i = 0; i < NREGS; i++) begin
            rel_amt = 2'(rel_e_en && (rel_e == 4'(i))) + 2'(rel_m_en && (rel_m == 4'(i)));
            inc_amt = 2'(inc_e == 4'(i)) + 2'(inc_m == 4'(i));
            wr_hit  = (wr_e_en && (rel_e == 4'(i))) || (rel_m_en && (rel_m == 4'(i)));
            // Releases floor at zero before this cycle's issue is added.
            after_rel = (CW'(count[i]) > CW'(rel_amt)) ? CW'(count[i]) - CW'(rel_amt) : '0;
            sum       = after_rel + CW'(inc_amt);
            sat_vec[i]    = (sum > CMAX);
            count_next[i] = inc_en ? sum[SB_W-1:0] : after_rel[SB_W-1:0];
            busy_vec[i]   = (count[i] > SB_W'(1)) || ((count[i] == SB_W'(1)) && !wr_hit);
        end
    end

    always_comb begin
        busy_a = 1'b0;
        busy_b = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            if (query_a == 4'(i)) busy_a = busy_vec[i];
            if (query_b == 4'(i)) busy_b = busy_vec[i];
        end
    end

    assign sat = |sat_vec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) count[i] <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) count[i] <= count_next[i];
        end
    end

endmodule

// File: rtl/y86_regfile_sb.sv
// Y86-64 decode stage: register file with two writeback ports, same-cycle
// bypass, scoreboard-based RAW stall and the decode->execute output register.
module y86_regfile_sb #(
    parameter int                DATA_W  = 64,
    parameter int                NREGS   = 15,
    parameter int                RSP     = 4,
    parameter int                SB_W    = 2,
    parameter logic [DATA_W-1:0] SP_INIT = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        icode,
    input  logic [3:0]        rA,
    input  logic [3:0]        rB,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_icode,
    output logic [DATA_W-1:0] valA,
    output logic [DATA_W-1:0] valB,
    output logic [3:0]        dstE,
    output logic [3:0]        dstM,
    input  logic              wE_en,
    input  logic              wE_rel,
    input  logic [3:0]        wE_dst,
    input  logic [DATA_W-1:0] wE_val,
    input  logic              wM_en,
    input  logic [3:0]        wM_dst,
    input  logic [DATA_W-1:0] wM_val,
    input  logic [3:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_val
);
    import y86_pkg::*;

    localparam logic [3:0] RSP4 = 4'(RSP);

    decode_t           dec;
    logic [DATA_W-1:0] regs [NREGS];
    logic [DATA_W-1:0] rf_a;
    logic [DATA_W-1:0] rf_b;
    logic [DATA_W-1:0] fwd_a;
    logic [DATA_W-1:0] fwd_b;
    logic              busy_a;
    logic              busy_b;
    logic              sat;
    logic              hazard;
    logic              accept;

    assign dec = y86_decode(icode, rA, rB, RSP4);

    // Unmatched or RNONE indices fall through the loop and read as zero.
    always_comb begin
        rf_a    = '0;
        rf_b    = '0;
        dbg_val = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (dec.src_a == 4'(i)) rf_a    = regs[i];
            if (dec.src_b == 4'(i)) rf_b    = regs[i];
            if (dbg_sel == 4'(i))   dbg_val = regs[i];
        end
    end

    // M has priority over E, matching the register-file write priority.
    always_comb begin
        fwd_a = rf_a;
        fwd_b = rf_b;
        if (dec.src_a != RNONE && dec.src_a < 4'(NREGS)) begin
            if (wM_en && wM_dst == dec.src_a)      fwd_a = wM_val;
            else if (wE_en && wE_dst == dec.src_a) fwd_a = wE_val;
        end
        if (dec.src_b != RNONE && dec.src_b < 4'(NREGS)) begin
            if (wM_en && wM_dst == dec.src_b)      fwd_b = wM_val;
            else if (wE_en && wE_dst == dec.src_b) fwd_b = wE_val;
        end
    end

    y86_scoreboard #(
        .NREGS (NREGS),
        .SB_W  (SB_W)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .inc_en   (accept),
        .inc_e    (dec.dst_e),
        .inc_m    (dec.dst_m),
        .rel_e_en (wE_en || wE_rel),
        .wr_e_en  (wE_en),
        .rel_e    (wE_dst),
        .rel_m_en (wM_en),
        .rel_m    (wM_dst),
        .query_a  (dec.src_a),
        .query_b  (dec.src_b),
        .busy_a   (busy_a),
        .busy_b   (busy_b),
        .sat      (sat)
    );

    // Handshake: a transfer occurs on any rising edge where valid && ready are
    // both high; a producer holds its payload stable while valid && !ready.
    assign hazard   = busy_a || busy_b || sat;
    assign in_ready = !hazard && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= (i == RSP) ? SP_INIT : '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (wM_en && wM_dst == 4'(i))      regs[i] <= wM_val;
                else if (wE_en && wE_dst == 4'(i)) regs[i] <= wE_val;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_icode <= 4'h0;
            valA      <= '0;
            valB      <= '0;
            dstE      <= RNONE;
            dstM      <= RNONE;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_icode <= icode;
            valA      <= fwd_a;
            valB      <= fwd_b;
            dstE      <= dec.dst_e;
            dstM      <= dec.dst_m;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/y86_regfile_sb.md
Name: y86_regfile_sb

Overview:
- Parametrised decode/register-file block for the pipelined Y86-64 core.
- Decodes srcA/srcB/dstE/dstM from icode/rA/rB and reads NREGS registers through two read ports.
- Accepts two writeback ports (E and M) with same-cycle bypass, and tracks in-flight destinations in a per-register scoreboard so it can stall on RAW hazards.
- Sits between the fetch stage and the execute-stage pipeline register; it drives that register's contents.

Parameters:
- DATA_W, 64, register/data width.
- NREGS, 15, architectural registers (indices 0..NREGS-1; 4'hF = RNONE).
- RSP, 4, stack-pointer index.
- SB_W, 2, scoreboard counter width (max outstanding writes per reg = 2^SB_W-1).
- SP_INIT, 0, reset value of register RSP (all others reset to 0).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  block accepts it this cycle.
- icode  in  4  instruction code.
- rA  in  4  register field A.
- rB  in  4  register field B.
- out_valid  out  1  registered decode result valid.
- out_ready  in  1  execute stage accepts the result.
- out_icode  out  4  registered icode.
- valA  out  DATA_W  registered source-A value.
- valB  out  DATA_W  registered source-B value.
- dstE  out  4  registered E destination.
- dstM  out  4  registered M destination.
- wE_en  in  1  write wE_val to wE_dst and release one scoreboard entry.
- wE_rel  in  1  release one scoreboard entry of wE_dst without writing (cmov not taken).
- wE_dst  in  4  E writeback register.
- wE_val  in  DATA_W  E writeback data.
- wM_en  in  1  write wM_val to wM_dst and release one scoreboard entry.
- wM_dst  in  4  M writeback register.
- wM_val  in  DATA_W  M writeback data.
- dbg_sel  in  4  debug register select.
- dbg_val  out  DATA_W  combinational read of register dbg_sel (0 when dbg_sel >= NREGS).

Behaviour:
- Reset (async): all registers 0 except reg[RSP]=SP_INIT; all scoreboard counters 0; out_valid=0, out_icode=0, valA=valB=0, dstE=dstM=4'hF.
- Decode is combinational, using Y86 rules:
  - srcA: rA for icode 2,4,6,A; RSP for B,9; else F.
  - srcB: rB for 4,5,6; RSP for 8,9,A,B; else F.
  - dstE: rB for 2,3,6; RSP for 8,9,A,B; else F.
  - dstM: rA for 5,B; else F.
- Bypass: a source equal to wM_dst with wM_en takes wM_val. Otherwise, a source equal to wE_dst with wE_en takes wE_val. Otherwise the source reads the register file. RNONE reads 0.
- Hazard on a source s != F:
  - count[s] > 1, or
  - count[s] == 1 and s is not being written this cycle by an enabled port.
- Capacity: a dst counter that would exceed 2^SB_W-1 after this cycle's releases also raises hazard.
- in_ready = !hazard && (!out_valid || out_ready).
- Accept (in_valid && in_ready):
  - Output register loads out_icode, valA, valB, dstE and dstM next edge; out_valid=1.
  - count[dstE]++ and count[dstM]++ (+2 if equal, e.g. popq %rsp). F is never counted.
- No accept and out_ready: out_valid clears. No accept and !out_ready: outputs hold.
- Writeback applies at the clock edge:
  - Both ports enabled to the same register: M wins the data write; both release.
  - Release of a counter already at 0 saturates at 0.
  - Writes to F or to an index >= NREGS are ignored.
- Per-register net count update = increments - releases in the same cycle.
- rst mid-operation flushes out_valid, all counters and all registers immediately.

Decomposition:
- Package y86_pkg holds the icode constants (IHALT..IPOPQ), RNONE=4'hF and RSP_IDX.
- One sub-module, y86_scoreboard: per-register counters with inc/release inputs and a busy/saturated query. Register array, bypass and output register stay in the top.

Test Plan:
- Reset with SP_INIT=64'h100, then dbg_sel=4 -> dbg_val=0x100; dbg_sel=3 -> 0; out_valid=0; dstE=dstM=F.
- irmovq rB=3 accepted, then wE_en wE_dst=3 wE_val=10 -> count[3] goes 1 then 0; dbg_sel=3 reads 10.
- irmovq rB=3 issued, then rrmovq rA=3 rB=5 held with no writeback -> in_ready=0 for 3 cycles. Next, wE_en dst=3 val=7 in the same cycle -> accepted, valA=7 the next cycle.
- Same-cycle wE_en dst=2 val=1 and wM_en dst=2 val=9 -> reg2=9; opq rA=2 decoded that cycle -> valA=9.
- popq rA=4 with SP_INIT=0x100 -> srcA=srcB=RSP, valA=valB=0x100, dstE=dstM=4, count[4]=2. Subsequent pushq stalls until both ports release.
- out_ready=0 for 2 cycles while out_valid=1 -> outputs stable and in_ready=0. Asserting rst mid-stall -> out_valid=0 and counts 0 asynchronously.
